mouse_track_canvas: RTL and testbench

MOUSE_TRACK_CANVAS -- requirements
Module: mouse_track_canvas

---
 rtl/mouse_track_canvas_if.sv | 30 +++
 rtl/mouse_track_canvas.sv | 181 ++++++++++++++++++
 tb/tb_mouse_track_canvas.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/mouse_track_canvas_if.sv
// Draw/clear command interface for mouse_track_canvas.
//   master : drives draw_valid, draw_x, draw_y, clear_req; observes busy
//   slave  : the canvas; consumes commands, drives busy
interface mouse_track_canvas_if #(
   parameter int unsigned BSIZE = 52
);
   localparam int unsigned CW = $clog2(BSIZE);

   logic          draw_valid;
   logic [CW-1:0] draw_x;
   logic [CW-1:0] draw_y;
   logic          clear_req;
   logic          busy;

   modport master (
      output draw_valid,
      output draw_x,
      output draw_y,
      output clear_req,
      input  busy
   );

   modport slave (
      input  draw_valid,
      input  draw_x,
      input  draw_y,
      input  clear_req,
      output busy
   );
endinterface

// File: rtl/mouse_track_canvas.sv
// Register-based BSIZE x BSIZE stroke canvas with a mirrored-raster display path.
// Ports:
//   clk, rst                     sole clock, synchronous active-high reset
//   block_x_pos, block_y_pos     canvas origin in mirrored screen coordinates
//   hcount, vcount               raster position
//   dilate_en                    plus-shaped stroke thickening on display
//   cmd (slave)                  draw_valid/draw_x/draw_y/clear_req in, busy out
//   track_out                    stored bitmap, bit row*BSIZE+col
//   pixel_count                  number of set cells
//   enable_track_display_out     stroke pixel, 2 cycles after hcount/vcount
//   red_out, green_out, blue_out stroke colour
module mouse_track_canvas #(
   parameter int unsigned H         = 480,
   parameter int unsigned W         = 640,
   parameter int unsigned BSIZE     = 52,
   parameter logic [11:0] TRACK_RGB = 12'h000
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic [9:0]                           block_x_pos,
   input  logic [9:0]                           block_y_pos,
   input  logic [9:0]                           hcount,
   input  logic [9:0]                           vcount,
   input  logic                                 dilate_en,
   mouse_track_canvas_if.slave                  cmd,
   output logic [BSIZE*BSIZE-1:0]               track_out,
   output logic [$clog2(BSIZE*BSIZE+1)-1:0]     pixel_count,
   output logic                                 enable_track_display_out,
   output logic [3:0]                           red_out,
   output logic [3:0]                           green_out,
   output logic [3:0]                           blue_out
);
   localparam int unsigned CW = $clog2(BSIZE);
   localparam int unsigned NW = $clog2(BSIZE*BSIZE+1);

   typedef enum logic [0:0] {StIdle, StClear} state_e;

   state_e            state_q, state_d;
   logic [CW-1:0]     row_ptr_q;
   logic [BSIZE-1:0]  rows_q [BSIZE];
   logic [NW-1:0]     count_q;
   logic              busy;
   logic              clear_start;
   logic              draw_acc;
   logic              cell_prev;

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk) begin
      if (rst) state_q <= StIdle;
      else     state_q <= state_d;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (cmd.clear_req) state_d = StClear;
         StClear: if (row_ptr_q == CW'(BSIZE - 1)) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      busy = 1'b0;
      unique case (state_q)
         StIdle:  busy = 1'b0;
         StClear: busy = 1'b1;
         default: busy = 1'b0;
      endcase
   end

   assign cmd.busy = busy;

   // ---------------- Storage and pixel count ----------------
   assign clear_start = (state_q == StIdle) && cmd.clear_req;
   // Clear wins over a draw on the same cycle; draws while wiping are dropped.
   assign draw_acc = (state_q == StIdle) && !cmd.clear_req && cmd.draw_valid &&
                     ({1'b0, cmd.draw_x} < (CW+1)'(BSIZE)) &&
                     ({1'b0, cmd.draw_y} < (CW+1)'(BSIZE));
   assign cell_prev = rows_q[cmd.draw_y][cmd.draw_x];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < int'(BSIZE); i++) rows_q[i] <= '0;
         count_q   <= '0;
         row_ptr_q <= '0;
      end else begin
         if (state_q == StClear) begin
            rows_q[row_ptr_q] <= '0;
            row_ptr_q         <= row_ptr_q + CW'(1);
         end else begin
            row_ptr_q <= '0;
            if (draw_acc) rows_q[cmd.draw_y][cmd.draw_x] <= 1'b1;
         end
         if (clear_start)                count_q <= '0;
         else if (draw_acc && !cell_prev) count_q <= count_q + NW'(1);
      end
   end

   always_comb begin
      for (int i = 0; i < int'(BSIZE); i++) track_out[i*BSIZE +: BSIZE] = rows_q[i];
   end

   assign pixel_count = count_q;

   // ---------------- Display stage 1 ----------------
   logic [9:0]       xcnt, ycnt;
   logic [10:0]      x_lo, x_hi, y_lo, y_hi;
   logic             in_canvas;
   logic [CW-1:0]    rel_col, rel_row;
   logic [BSIZE-1:0] row_m, row_c, row_p;

   always_comb begin
      xcnt      = 10'(W - 1) - hcount;
      ycnt      = 10'(H - 1) - vcount;
      // 11-bit bounds so origin + BSIZE never wraps.
      x_lo      = {1'b0, block_x_pos};
      x_hi      = x_lo + 11'(BSIZE);
      y_lo      = {1'b0, block_y_pos};
      y_hi      = y_lo + 11'(BSIZE);
      in_canvas = ({1'b0, xcnt} >= x_lo) && ({1'b0, xcnt} < x_hi) &&
                  ({1'b0, ycnt} >= y_lo) && ({1'b0, ycnt} < y_hi);
      rel_col   = CW'(xcnt - block_x_pos);
      rel_row   = CW'(ycnt - block_y_pos);
      // Loop-based row select: rows outside 0..BSIZE-1 read as zero.
      row_m = '0;
      row_c = '0;
      row_p = '0;
      for (int i = 0; i < int'(BSIZE); i++) begin
         if (i + 1 == int'(rel_row)) row_m = rows_q[i];
         if (i == int'(rel_row))     row_c = rows_q[i];
         if (i == int'(rel_row) + 1) row_p = rows_q[i];
      end
   end

   logic             in_q, dil_q;
   logic [CW-1:0]    col_q;
   logic [BSIZE-1:0] row_m_q, row_c_q, row_p_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         in_q    <= 1'b0;
         dil_q   <= 1'b0;
         col_q   <= '0;
         row_m_q <= '0;
         row_c_q <= '0;
         row_p_q <= '0;
      end else begin
         in_q    <= in_canvas;
         dil_q   <= dilate_en;
         col_q   <= rel_col;
         row_m_q <= row_m;
         row_c_q <= row_c;
         row_p_q <= row_p;
      end
   end

   // ---------------- Display stage 2 ----------------
   logic [BSIZE-1:0] disp_vec;
   logic             pix;

   always_comb begin
      // Shifts zero-fill, so left/right neighbours beyond the canvas edge are 0.
      disp_vec = row_c_q;
      if (dil_q) disp_vec = row_c_q | row_m_q | row_p_q | (row_c_q << 1) | (row_c_q >> 1);
      pix = 1'b0;
      for (int i = 0; i < int'(BSIZE); i++) begin
         if (i == int'(col_q)) pix = disp_vec[i];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) enable_track_display_out <= 1'b0;
      else     enable_track_display_out <= in_q && pix;
   end

   assign red_out   = TRACK_RGB[11:8];
   assign green_out = TRACK_RGB[7:4];
   assign blue_out  = TRACK_RGB[3:0];
endmodule

// File: tb/tb_mouse_track_canvas.sv
// Directed bench for mouse_track_canvas (BSIZE=52, origin 100,50).
// Expected display values are queued when a raster position is driven and
// compared when the 2-cycle pipeline delivers them.
module tb_mouse_track_canvas;
   localparam int unsigned BSIZE = 52;
   localparam int unsigned NW    = $clog2(BSIZE*BSIZE+1);

   logic                     clk = 1'b0;
   logic                     rst;
   logic [9:0]               block_x_pos, block_y_pos, hcount, vcount;
   logic                     dilate_en;
   logic [BSIZE*BSIZE-1:0]   track_out;
   logic [NW-1:0]            pixel_count;
   logic                     enable;
   logic [3:0]               red_out, green_out, blue_out;

   always #5 clk = ~clk;

   mouse_track_canvas_if #(.BSIZE(BSIZE)) cmd_if ();

   mouse_track_canvas #(
      .H(480), .W(640), .BSIZE(BSIZE), .TRACK_RGB(12'h000)
   ) dut (
      .clk                      (clk),
      .rst                      (rst),
      .block_x_pos              (block_x_pos),
      .block_y_pos              (block_y_pos),
      .hcount                   (hcount),
      .vcount                   (vcount),
      .dilate_en                (dilate_en),
      .cmd                      (cmd_if.slave),
      .track_out                (track_out),
      .pixel_count              (pixel_count),
      .enable_track_display_out (enable),
      .red_out                  (red_out),
      .green_out                (green_out),
      .blue_out                 (blue_out)
   );

   typedef struct {
      string tag;
      logic  exp;
   } sb_t;

   sb_t sb_q[$];
   int  pass_cnt  = 0;
   int  total_cnt = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic draw(input int y, input int x);
      cmd_if.draw_valid = 1'b1;
      cmd_if.draw_x     = 6'(x);
      cmd_if.draw_y     = 6'(y);
      step();
      cmd_if.draw_valid = 1'b0;
   endtask

   task automatic raster(input int h, input int v, input logic exp, input string tag);
      sb_t e;
      hcount = 10'(h);
      vcount = 10'(v);
      sb_q.push_back('{tag: tag, exp: exp});
      step();
      step();
      e = sb_q.pop_front();
      check(e.tag, 64'(enable), 64'(e.exp));
   endtask

   task automatic wipe(input string tag);
      int guard;
      cmd_if.clear_req = 1'b1;
      step();
      cmd_if.clear_req = 1'b0;
      guard = 0;
      while (cmd_if.busy && guard < 200) begin
         step();
         guard++;
      end
      check(tag, 64'(cmd_if.busy), 64'd0);
   endtask

   initial begin
      sb_t e;
      int  n;
      int  guard;

      rst               = 1'b1;
      block_x_pos       = 10'd100;
      block_y_pos       = 10'd50;
      hcount            = 10'd0;
      vcount            = 10'd0;
      dilate_en         = 1'b0;
      cmd_if.draw_valid = 1'b0;
      cmd_if.draw_x     = '0;
      cmd_if.draw_y     = '0;
      cmd_if.clear_req  = 1'b0;
      step();
      step();
      check("rst_busy",   64'(cmd_if.busy), 64'd0);
      check("rst_count",  64'(pixel_count), 64'd0);
      check("rst_track",  64'($countones(track_out)), 64'd0);
      check("rst_enable", 64'(enable), 64'd0);
      check("colour",     64'({red_out, green_out, blue_out}), 64'h000);
      rst = 1'b0;
      step();

      // Single cell, no dilation; verify exact 2-cycle latency.
      draw(10, 20);
      check("count_one", 64'(pixel_count), 64'd1);
      check("bit_10_20", 64'(track_out[10*52+20]), 64'd1);
      step();
      step();
      hcount = 10'd519;
      vcount = 10'd419;
      sb_q.push_back('{tag: "lat2_hit", exp: 1'b1});
      step();
      check("lat1_early", 64'(enable), 64'd0);
      step();
      e = sb_q.pop_front();
      check(e.tag, 64'(enable), 64'(e.exp));
      raster(518, 419, 1'b0, "nodil_right");
      raster(519, 418, 1'b0, "nodil_down");

      // Plus-shaped dilation.
      dilate_en = 1'b1;
      raster(518, 419, 1'b1, "dil_h518");
      raster(520, 419, 1'b1, "dil_h520");
      raster(519, 418, 1'b1, "dil_v418");
      raster(519, 420, 1'b1, "dil_v420");
      raster(517, 419, 1'b0, "dil_h517");
      raster(518, 418, 1'b0, "dil_diag");
      dilate_en = 1'b0;

      // Clear with a simultaneous draw; draw and second clear_req while busy.
      cmd_if.clear_req  = 1'b1;
      cmd_if.draw_valid = 1'b1;
      cmd_if.draw_x     = 6'd30;
      cmd_if.draw_y     = 6'd30;
      step();
      cmd_if.clear_req  = 1'b0;
      cmd_if.draw_valid = 1'b0;
      check("clr_busy_entry",  64'(cmd_if.busy), 64'd1);
      check("clr_count_entry", 64'(pixel_count), 64'd0);
      n     = 1;
      guard = 0;
      while (cmd_if.busy && guard < 200) begin
         cmd_if.draw_valid = (n == 5);
         cmd_if.draw_x     = 6'd1;
         cmd_if.draw_y     = 6'd1;
         cmd_if.clear_req  = (n == 10);
         step();
         guard++;
         if (cmd_if.busy) n++;
      end
      cmd_if.draw_valid = 1'b0;
      cmd_if.clear_req  = 1'b0;
      check("clr_busy_cycles", 64'(n), 64'd52);
      check("clr_track_zero",  64'($countones(track_out)), 64'd0);
      check("clr_count_zero",  64'(pixel_count), 64'd0);
      step();
      check("clr_no_restart",  64'(cmd_if.busy), 64'd0);

      // Redraws and out-of-range draws.
      draw(0, 0);
      draw(5, 5);
      draw(5, 5);
      draw(3, 60);
      draw(60, 3);
      check("oor_count", 64'(pixel_count), 64'd2);
      check("oor_bit0",  64'(track_out[0]), 64'd1);
      check("oor_bit265", 64'(track_out[265]), 64'd1);
      check("oor_ones",  64'($countones(track_out)), 64'd2);

      // Edge dilation at cell (0,51).
      wipe("wipe_done");
      dilate_en = 1'b1;
      draw(0, 51);
      raster(488, 429, 1'b1, "edge_r0c51");
      raster(488, 428, 1'b1, "edge_r1c51");
      raster(489, 429, 1'b1, "edge_r0c50");
      raster(487, 429, 1'b0, "edge_beyond_col");
      raster(488, 430, 1'b0, "edge_beyond_row");
      dilate_en = 1'b0;
      raster(488, 428, 1'b0, "edge_nodil");

      // Reset in the middle of a wipe overrides clear_req and draw_valid.
      draw(20, 20);
      raster(488, 429, 1'b1, "pre_rst_en");
      cmd_if.clear_req = 1'b1;
      step();
      cmd_if.clear_req = 1'b0;
      for (int i = 1; i < 20; i++) step();
      check("mid_clear_busy", 64'(cmd_if.busy), 64'd1);
      rst               = 1'b1;
      cmd_if.clear_req  = 1'b1;
      cmd_if.draw_valid = 1'b1;
      cmd_if.draw_x     = 6'd7;
      cmd_if.draw_y     = 6'd7;
      step();
      rst               = 1'b0;
      cmd_if.clear_req  = 1'b0;
      cmd_if.draw_valid = 1'b0;
      check("rst_mid_busy",   64'(cmd_if.busy), 64'd0);
      check("rst_mid_track",  64'($countones(track_out)), 64'd0);
      check("rst_mid_count",  64'(pixel_count), 64'd0);
      check("rst_mid_enable", 64'(enable), 64'd0);
      step();
      check("rst_mid_idle",   64'(cmd_if.busy), 64'd0);
      draw(7, 7);
      check("post_rst_draw",  64'(pixel_count), 64'd1);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
